mac_acc_drain: RTL and testbench
================================

Name: mac_acc_drain

Overview:
- Read-side counterpart of the fused signed MAC (one 32-bit accumulator, or two 24-bit accumulators when split).
- Accepts the packed 48-bit accumulator word over a valid/ready handshake and unpacks it into one or two signed lanes.
- Applies a programmable arithmetic right shift, with optional rounding, then signed saturation to OUT_W.
- Emits one OUT_W result per output handshake toward the conv output writeback.

Parameters:
- ACC_W, 48, packed accumulator word width
- FULL_W, 32, non-split lane width, in_data[31:0]
- LANE_W, 24, split lane width: lane0 = in_data[23:0], lane1 = in_data[47:24]
- OUT_W, 8, signed output width

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  packed accumulator word valid
- in_ready  out  1  block can accept a word this cycle
- in_data  in  ACC_W  packed accumulator word
- in_split  in  1  1 = two LANE_W lanes, 0 = one FULL_W lane
- shift  in  5  right-shift amount, sampled at accept
- round_en  in  1  round-half-up enable, sampled at accept
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts the result
- out_data  out  OUT_W  saturated signed result
- out_lane  out  1  lane index of out_data (0 or 1)
- out_last  out  1  final result of the accepted word
- out_sat  out  1  saturation occurred on this result

Behaviour:
- Clock and reset: single clock clk; rst is synchronous, active-high.
- Reset values: out_valid=0, out_data=0, out_lane=0, out_last=0, out_sat=0, FSM=IDLE, captured word and controls cleared. in_ready=1 in the cycle after reset deasserts.
- Accept rule: a word is accepted on a cycle with in_valid && in_ready. in_data, in_split, shift and round_en are captured on that cycle.
- FSM states: IDLE, EMIT0, EMIT1.
  - IDLE: in_ready=1. Accept -> EMIT0.
  - EMIT0: holds lane0 (non-split: the FULL_W lane). out_valid=1.
    - Non-split: out_last=1.
    - Split: out_last=0. out_ready -> EMIT1.
  - EMIT1: holds lane1. out_valid=1, out_lane=1, out_last=1.
  - Last result consumed (out_ready while out_last=1): go to EMIT0 if a new word is accepted the same cycle, else IDLE.
- in_ready: 1 in IDLE, or when the last result is being consumed this cycle (combinational on out_ready). This gives non-split throughput of 1 word/cycle and split throughput of 1 word per 2 cycles.
- Latency: out_valid rises the cycle after accept. There is no combinational path from in_data to out_data.
- Output stability: while out_valid && !out_ready, out_data, out_lane, out_last and out_sat hold stable.
- Lane extraction, split=1:
  - Lane0 is signed in_data[23:0]; lane1 is signed in_data[47:24].
  - Lanes are independent: no carry or sign is taken across bit 24.
- Lane extraction, split=0:
  - The lane is signed in_data[31:0]; in_data[47:32] is ignored.
- Arithmetic on the selected lane, signed value v:
  - Shift clamp: shift is clamped to 31 (non-split) or 23 (split).
  - Rounding: if round_en and shift>0, r = (v + 2^(shift-1)) >>> shift, with the add done one bit wider so it cannot wrap. Otherwise r = v >>> shift.
  - Saturation to OUT_W signed: r > 127 gives 127; r < -128 gives -128. out_sat=1 when clamped.
- Ignored signals: in_valid while in_ready=0 is ignored, and the word is not captured.
- Reset mid-operation: any pending results are discarded without emission, and outputs return to reset values.

Decomposition:
- Shared package mac_pkg:
  - Constants ACC_W, FULL_W, LANE_W, OUT_W.
  - FSM state enum with IDLE/EMIT0/EMIT1.
- Sub-module acc_requant (combinational):
  - Inputs: signed value, lane-width select, shift, round_en.
  - Outputs: OUT_W result and sat flag.
  - Instantiated once and muxed between lanes by FSM state.

Test Plan:
- Non-split, in_data=0x0000_0000_0058, shift=4:
  - round_en=0 -> one result, out_data=0x05, out_lane=0, out_last=1, out_sat=0.
  - round_en=1 -> out_data=0x06.
- Non-split negatives:
  - in_data[31:0]=0xFFFF_FF00, shift=1 -> out_data=0x80, out_sat=0.
  - Same word with shift=0 -> out_data=0x80, out_sat=1.
  - in_data[47:32]=0xABCD -> results unaffected.
- Split, in_data={24'hFFFFF0, 24'h000070}, shift=0 -> two beats:
  - Beat 1: 0x70, out_lane=0, out_last=0.
  - Beat 2: 0xF0, out_lane=1, out_last=1.
  - in_ready is low during beat 1.
- Split saturation, lane0=24'h7FFFFF, lane1=24'h800000, shift=8 -> 0x7F with out_sat=1, then 0x80 with out_sat=1. Checks that no cross-lane carry occurs.
- Backpressure: hold out_ready=0 for 3 cycles during a pending result -> outputs stable and in_ready=0. Then feed back-to-back non-split words with out_ready=1 -> one result per cycle, none dropped.
- Reset during EMIT0 of a split word: assert rst for 1 cycle -> next cycle out_valid=0, in_ready=1, and lane1 of that word is never emitted.

Source files
------------

// File: rtl/mac_pkg.sv
// Shared constants and FSM encoding for the accumulator drain path.
package mac_pkg;

  localparam int ACC_W   = 48;
  localparam int FULL_W  = 32;
  localparam int LANE_W  = 24;
  localparam int OUT_W   = 8;
  localparam int SHIFT_W = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    EMIT0 = 2'd1,
    EMIT1 = 2'd2
  } state_e;

endpackage

// File: rtl/acc_requant.sv
// Combinational requantiser: clamped arithmetic right shift with optional
// round-half-up, then signed saturation to OUT_W.
module acc_requant
  import mac_pkg::*;
(
  input  logic signed [FULL_W-1:0]  value_i,
  input  logic                      split_i,
  input  logic        [SHIFT_W-1:0] shift_i,
  input  logic                      round_en_i,
  output logic        [OUT_W-1:0]   result_o,
  output logic                      sat_o
);

  localparam int SUM_W = FULL_W + 1;
  localparam logic signed [SUM_W-1:0] MAX_V = SUM_W'((2 ** (OUT_W - 1)) - 1);
  localparam logic signed [SUM_W-1:0] MIN_V = -MAX_V - SUM_W'(1);

  logic        [SHIFT_W-1:0] shamt;
  logic        [SUM_W-1:0]   bias;
  logic signed [SUM_W-1:0]   sum;
  logic signed [SUM_W-1:0]   shifted;

  always_comb begin
    shamt = shift_i;
    if (split_i && (shift_i > SHIFT_W'(LANE_W - 1))) begin
      shamt = SHIFT_W'(LANE_W - 1);
    end

    // One extra bit of headroom keeps v + 2^(shift-1) from wrapping.
    bias = '0;
    if (round_en_i && (shamt != '0)) begin
      bias = SUM_W'(1) << (shamt - SHIFT_W'(1));
    end
    sum     = {value_i[FULL_W-1], value_i} + bias;
    shifted = sum >>> shamt;

    result_o = shifted[OUT_W-1:0];
    sat_o    = 1'b0;
    if (shifted > MAX_V) begin
      result_o = MAX_V[OUT_W-1:0];
      sat_o    = 1'b1;
    end else if (shifted < MIN_V) begin
      result_o = MIN_V[OUT_W-1:0];
      sat_o    = 1'b1;
    end
  end

endmodule

// File: rtl/mac_acc_drain.sv
// Drains packed MAC accumulator words into one or two saturated OUT_W results
// per word over valid/ready handshakes on both sides.
module mac_acc_drain
  import mac_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [ACC_W-1:0]   in_data,
  input  logic               in_split,
  input  logic [SHIFT_W-1:0] shift,
  input  logic               round_en,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [OUT_W-1:0]   out_data,
  output logic               out_lane,
  output logic               out_last,
  output logic               out_sat
);

  state_e             state_q, state_d;
  logic [ACC_W-1:0]   data_q, data_d;
  logic               split_q, split_d;
  logic [SHIFT_W-1:0] shift_q, shift_d;
  logic               round_q, round_d;

  logic signed [FULL_W-1:0] lane_value;
  logic        [OUT_W-1:0]  req_result;
  logic                     req_sat;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      data_q  <= '0;
      split_q <= 1'b0;
      shift_q <= '0;
      round_q <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      split_q <= split_d;
      shift_q <= shift_d;
      round_q <= round_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    split_d   = split_q;
    shift_d   = shift_q;
    round_d   = round_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_lane  = 1'b0;
    out_last  = 1'b0;

    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
      end
      EMIT0: begin
        out_valid = 1'b1;
        out_last  = !split_q;
        if (out_ready) begin
          if (split_q) begin
            state_d = EMIT1;
          end else begin
            in_ready = 1'b1;
            state_d  = IDLE;
          end
        end
      end
      EMIT1: begin
        out_valid = 1'b1;
        out_lane  = 1'b1;
        out_last  = 1'b1;
        if (out_ready) begin
          in_ready = 1'b1;
          state_d  = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Accepting while the last result drains keeps back-to-back words gapless.
    if (in_valid && in_ready) begin
      data_d  = in_data;
      split_d = in_split;
      shift_d = shift;
      round_d = round_en;
      state_d = EMIT0;
    end
  end

  always_comb begin
    if (state_q == EMIT1) begin
      lane_value = FULL_W'($signed(data_q[ACC_W-1:LANE_W]));
    end else if (split_q) begin
      lane_value = FULL_W'($signed(data_q[LANE_W-1:0]));
    end else begin
      lane_value = data_q[FULL_W-1:0];
    end
  end

  acc_requant u_requant (
    .value_i    (lane_value),
    .split_i    (split_q),
    .shift_i    (shift_q),
    .round_en_i (round_q),
    .result_o   (req_result),
    .sat_o      (req_sat)
  );

  assign out_data = out_valid ? req_result : '0;
  assign out_sat  = out_valid & req_sat;

endmodule

// File: tb/tb_mac_acc_drain.sv
// Randomised plus directed bench for mac_acc_drain against an arithmetic
// reference model and result scoreboard.
module tb_mac_acc_drain;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [47:0] in_data;
  logic        in_split;
  logic [4:0]  shift;
  logic        round_en;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic        out_lane;
  logic        out_last;
  logic        out_sat;

  typedef struct {
    logic [7:0] d;
    logic       lane;
    logic       last;
    logic       sat;
  } res_t;

  res_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   accepted;

  always #5 clk = ~clk;

  mac_acc_drain dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_split  (in_split),
    .shift     (shift),
    .round_en  (round_en),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_lane  (out_lane),
    .out_last  (out_last),
    .out_sat   (out_sat)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: floor((v + round_bias) / 2^sh), then clamp to [-128, 127].
  function automatic res_t model(longint v, int sh, bit rn, bit lane, bit last);
    res_t   r;
    longint q;
    longint bias;
    bias = (rn && sh > 0) ? (longint'(1) << (sh - 1)) : 0;
    q = (v + bias) >>> sh;
    r.sat = 1'b0;
    if (q > 127) begin
      q = 127;
      r.sat = 1'b1;
    end else if (q < -128) begin
      q = -128;
      r.sat = 1'b1;
    end
    r.d    = q[7:0];
    r.lane = lane;
    r.last = last;
    return r;
  endfunction

  function automatic void push_word(logic [47:0] d, bit sp, int sh, bit rn);
    int s;
    if (sp) begin
      s = (sh > 23) ? 23 : sh;
      exp_q.push_back(model(longint'($signed(d[23:0])), s, rn, 1'b0, 1'b0));
      exp_q.push_back(model(longint'($signed(d[47:24])), s, rn, 1'b1, 1'b1));
    end else begin
      exp_q.push_back(model(longint'($signed(d[31:0])), sh, rn, 1'b0, 1'b1));
    end
  endfunction

  // One clock: check outputs against the scoreboard head, then advance.
  task automatic do_cycle();
    bit exp_ready;
    accepted = 1'b0;
    #1;
    chk("out_valid", 64'(out_valid), 64'(exp_q.size() != 0));
    exp_ready = (exp_q.size() == 0) || (exp_q.size() == 1 && out_ready);
    chk("in_ready", 64'(in_ready), 64'(exp_ready));
    if (out_valid && exp_q.size() != 0) begin
      chk("out_data", 64'(out_data), 64'(exp_q[0].d));
      chk("out_lane", 64'(out_lane), 64'(exp_q[0].lane));
      chk("out_last", 64'(out_last), 64'(exp_q[0].last));
      chk("out_sat",  64'(out_sat),  64'(exp_q[0].sat));
      if (out_ready) void'(exp_q.pop_front());
    end
    if (in_valid && in_ready) begin
      push_word(in_data, in_split, int'(shift), round_en);
      accepted = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send(input logic [47:0] d, input bit sp, input logic [4:0] sh, input bit rn);
    bit done = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    in_split = sp;
    shift    = sh;
    round_en = rn;
    for (int n = 0; n < 50 && !done; n++) begin
      do_cycle();
      done = accepted;
    end
    if (!done) chk("send_timeout", 64'(0), 64'(1));
    in_valid = 1'b0;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int n = 0; n < 20 && exp_q.size() != 0; n++) do_cycle();
    if (exp_q.size() != 0) chk("drain_timeout", 64'(exp_q.size()), 64'(0));
  endtask

  task automatic expect_out(input string tag, input logic [7:0] d, input bit lane,
                            input bit last, input bit sat);
    chk({tag, "_data"}, 64'(out_data), 64'(d));
    chk({tag, "_lane"}, 64'(out_lane), 64'(lane));
    chk({tag, "_last"}, 64'(out_last), 64'(last));
    chk({tag, "_sat"},  64'(out_sat),  64'(sat));
  endtask

  initial begin
    logic [63:0] rnd;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_split  = 1'b0;
    shift     = '0;
    round_en  = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    expect_out("rst", 8'h00, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    do_cycle();

    // Positive non-split, truncating then rounding.
    out_ready = 1'b0;
    send(48'h0000_0000_0058, 1'b0, 5'd4, 1'b0);
    expect_out("ns_trunc", 8'h05, 1'b0, 1'b1, 1'b0);
    drain();
    out_ready = 1'b0;
    send(48'h0000_0000_0058, 1'b0, 5'd4, 1'b1);
    expect_out("ns_round", 8'h06, 1'b0, 1'b1, 1'b0);
    drain();

    // Negative non-split, boundary and saturation, upper bits ignored.
    out_ready = 1'b0;
    send(48'h0000_FFFF_FF00, 1'b0, 5'd1, 1'b0);
    expect_out("ns_neg", 8'h80, 1'b0, 1'b1, 1'b0);
    drain();
    out_ready = 1'b0;
    send(48'h0000_FFFF_FF00, 1'b0, 5'd0, 1'b0);
    expect_out("ns_negsat", 8'h80, 1'b0, 1'b1, 1'b1);
    drain();
    out_ready = 1'b0;
    send(48'hABCD_FFFF_FF00, 1'b0, 5'd1, 1'b0);
    expect_out("ns_upper", 8'h80, 1'b0, 1'b1, 1'b0);
    drain();

    // Split word, two beats.
    out_ready = 1'b0;
    send({24'hFFFFF0, 24'h000070}, 1'b1, 5'd0, 1'b0);
    expect_out("sp_b0", 8'h70, 1'b0, 1'b0, 1'b0);
    chk("sp_b0_in_ready", 64'(in_ready), 64'(0));
    out_ready = 1'b1;
    do_cycle();
    expect_out("sp_b1", 8'hF0, 1'b1, 1'b1, 1'b0);
    drain();

    // Split saturation with no carry across lanes.
    out_ready = 1'b0;
    send({24'h800000, 24'h7FFFFF}, 1'b1, 5'd8, 1'b0);
    expect_out("spsat_b0", 8'h7F, 1'b0, 1'b0, 1'b1);
    out_ready = 1'b1;
    do_cycle();
    expect_out("spsat_b1", 8'h80, 1'b1, 1'b1, 1'b1);
    drain();

    // Backpressure: outputs hold and new words are refused.
    out_ready = 1'b0;
    send(48'h0000_0000_1234, 1'b0, 5'd3, 1'b1);
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data  = 48'h0000_0000_0100 + 48'(i);
      in_split = 1'b0;
      do_cycle();
      chk("bp_no_accept", 64'(accepted), 64'(0));
    end
    // Back-to-back non-split words at full rate.
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      rnd = {$urandom, $urandom};
      in_valid = 1'b1;
      in_data  = rnd[47:0];
      in_split = 1'b0;
      shift    = 5'($urandom_range(0, 31));
      round_en = 1'($urandom_range(0, 1));
      do_cycle();
      chk("b2b_accept", 64'(accepted), 64'(1));
    end
    in_valid = 1'b0;
    drain();

    // Reset while lane0 of a split word is pending.
    out_ready = 1'b0;
    send({24'h000011, 24'h000022}, 1'b1, 5'd0, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    #1;
    chk("mid_rst_out_valid", 64'(out_valid), 64'(0));
    chk("mid_rst_in_ready", 64'(in_ready), 64'(1));
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) do_cycle();

    // Random traffic on both handshakes.
    for (int i = 0; i < 400; i++) begin
      rnd = {$urandom, $urandom};
      if ($urandom_range(0, 1) == 1) rnd = 64'($signed(rnd[19:0]));
      in_valid  = 1'($urandom_range(0, 1));
      in_data   = rnd[47:0];
      in_split  = 1'($urandom_range(0, 1));
      shift     = 5'($urandom_range(0, 31));
      round_en  = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      do_cycle();
    end
    in_valid = 1'b0;
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
